reg_bank: RTL and testbench
===========================

# reg_bank

Destination register bank of the single-core datapath. It captures the 16-bit shared bus into one selected register per cycle and performs the increment and clear micro-operations the control unit issues. It also drives the register values that feed back into the bus source multiplexer and into the data-memory address. It sits directly downstream of the bus mux and directly upstream of its source inputs, closing the register-transfer loop.

## Interface
Parameters: none; widths are fixed by the datapath.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- busin  in  16  current bus value (bus mux output)
- write_en  in  4  destination select code:
  - 0 none, 1 ar, 2 pc, 3 dr, 4 r, 5 ac
  - 6 tr, 7 r1, 8 r2, 9 ri, 10 rj, 11 rk
  - 12–15 none
- inc_en  in  5  increment request bits: [0] pc, [1] ri, [2] rj, [3] rk, [4] ac
- clr_en  in  4  clear request bits: [0] ri, [1] rj, [2] rk, [3] ac
- ar  out  8  data-memory address register
- pc  out  8  program counter
- dr  out  8  data register
- r  out  8  general register
- ac  out  16  accumulator
- tr  out  16  temporary register
- r1  out  8  operand register 1
- r2  out  8  operand register 2
- ri  out  8  loop index i
- rj  out  8  loop index j
- rk  out  8  loop index k
- z  out  1  accumulator-zero flag, combinational: 1 iff ac == 16'd0

## Operation
- At most one register loads per cycle, selected by write_en.
  - Codes 0 and 12–15 load nothing.
- Width rules:
  - 16-bit destinations (ac, tr) take busin[15:0].
  - 8-bit destinations take busin[7:0]; busin[15:8] is discarded.
- Increment:
  - Each register adds 1 at its own width and wraps modulo 2^width.
    - pc 8'hFF → 8'h00
    - ac 16'hFFFF → 16'h0000
  - Any combination of inc_en bits may be active in the same cycle.
  - Registers not selected by any control hold their value.
- Clear: each register with its clr_en bit set goes to 0.
- Per-register priority when controls coincide on the same register: clear > load > increment.
  - ri with clr_en[0]=1, write_en=9, inc_en[1]=1 → ri=0.
  - pc with write_en=2 and inc_en[0]=1 → pc=busin[7:0], not busin+1.
- Controls aimed at different registers act independently in the same cycle.
  - Example: load r1 plus increment ri plus clear ac all take effect together.
- Loads capture the busin value present before the edge. Because bus sources include this block's own outputs, a transfer such as write_en=5 with the bus selecting ac is a hold, not a race.
- All control inputs are level-sampled per cycle. There is no handshake; the control unit owns sequencing.
- z follows ac combinationally, so it is valid in the same cycle ac updates.

## Timing
- Reset (rst_n low, asynchronous): every register output is 0 immediately, independent of clk. Consequently z=1.
- While rst_n is low, all controls are ignored.
- Release of rst_n is synchronous in effect: the first update occurs on the first rising clk edge with rst_n high.
- Reset mid-operation (asserted between edges) discards any pending load or increment. No partial update is visible.
- Latency:
  - One cycle from control and busin valid to the register output.
  - Outputs change only on the rising edge or on reset.
- Throughput: one load plus up to five increments and four clears per cycle.
- No combinational path from any input to any register output. The only combinational output is z, which depends on ac only.

## Test plan
- Reset: drive random values into all registers, assert rst_n low mid-cycle → all outputs read 0 before the next edge, z=1; release → registers hold 0 until a control is issued.
- Load sweep: busin=16'hA55A, step write_en through 1–11 → 8-bit registers read 8'h5A, ac and tr read 16'hA55A; codes 0 and 12–15 change nothing.
- Wrap-around:
  - pc=8'hFF with inc_en[0] → 8'h00.
  - ac=16'hFFFF with inc_en[4] → 16'h0000 and z rises in the same cycle.
  - ri=8'hFF with inc_en[1] → 8'h00.
- Priority on one register:
  - rk=8'h10, busin=16'h0033, write_en=11, inc_en[3]=1 → rk=8'h33.
  - Add clr_en[2]=1 on the same setup → rk=8'h00.
- Concurrent independent ops: ri=3, rj=7, ac=16'h0100, busin=16'h0042; one cycle with write_en=7, inc_en=5'b00110, clr_en=4'b1000 → r1=8'h42, ri=4, rj=8, ac=0, z=1; all other registers unchanged.
- Self-transfer hold: ac=16'h1234, busin driven with ac, write_en=5 for 10 cycles → ac stays 16'h1234, z=0 throughout.

Source files
------------

// File: rtl/reg_bank.sv
// Destination register bank: captures the shared bus into one selected register
// per cycle and applies the increment/clear micro-operations from the control unit.
module reg_bank (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] busin,
  input  logic [3:0]  write_en,
  input  logic [4:0]  inc_en,
  input  logic [3:0]  clr_en,
  output logic [7:0]  ar,
  output logic [7:0]  pc,
  output logic [7:0]  dr,
  output logic [7:0]  r,
  output logic [15:0] ac,
  output logic [15:0] tr,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  ri,
  output logic [7:0]  rj,
  output logic [7:0]  rk,
  output logic        z
);

  typedef enum logic [3:0] {
    DST_NONE = 4'd0,
    DST_AR   = 4'd1,
    DST_PC   = 4'd2,
    DST_DR   = 4'd3,
    DST_R    = 4'd4,
    DST_AC   = 4'd5,
    DST_TR   = 4'd6,
    DST_R1   = 4'd7,
    DST_R2   = 4'd8,
    DST_RI   = 4'd9,
    DST_RJ   = 4'd10,
    DST_RK   = 4'd11
  } dst_e;

  logic [7:0]  r_ar, r_pc, r_dr, r_r, r_r1, r_r2, r_ri, r_rj, r_rk;
  logic [15:0] r_ac, r_tr;
  logic [7:0]  w_ar_nxt, w_pc_nxt, w_dr_nxt, w_r_nxt, w_r1_nxt, w_r2_nxt;
  logic [7:0]  w_ri_nxt, w_rj_nxt, w_rk_nxt;
  logic [15:0] w_ac_nxt, w_tr_nxt;

  // Later assignments override earlier ones: clear > load > increment.
  always_comb begin
    w_ar_nxt = r_ar;
    w_pc_nxt = r_pc;
    w_dr_nxt = r_dr;
    w_r_nxt  = r_r;
    w_ac_nxt = r_ac;
    w_tr_nxt = r_tr;
    w_r1_nxt = r_r1;
    w_r2_nxt = r_r2;
    w_ri_nxt = r_ri;
    w_rj_nxt = r_rj;
    w_rk_nxt = r_rk;

    if (inc_en[0]) w_pc_nxt = r_pc + 8'd1;
    if (inc_en[1]) w_ri_nxt = r_ri + 8'd1;
    if (inc_en[2]) w_rj_nxt = r_rj + 8'd1;
    if (inc_en[3]) w_rk_nxt = r_rk + 8'd1;
    if (inc_en[4]) w_ac_nxt = r_ac + 16'd1;

    case (write_en)
      DST_AR:  w_ar_nxt = busin[7:0];
      DST_PC:  w_pc_nxt = busin[7:0];
      DST_DR:  w_dr_nxt = busin[7:0];
      DST_R:   w_r_nxt  = busin[7:0];
      DST_AC:  w_ac_nxt = busin;
      DST_TR:  w_tr_nxt = busin;
      DST_R1:  w_r1_nxt = busin[7:0];
      DST_R2:  w_r2_nxt = busin[7:0];
      DST_RI:  w_ri_nxt = busin[7:0];
      DST_RJ:  w_rj_nxt = busin[7:0];
      DST_RK:  w_rk_nxt = busin[7:0];
      default: ;
    endcase

    if (clr_en[0]) w_ri_nxt = '0;
    if (clr_en[1]) w_rj_nxt = '0;
    if (clr_en[2]) w_rk_nxt = '0;
    if (clr_en[3]) w_ac_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar <= '0;
      r_pc <= '0;
      r_dr <= '0;
      r_r  <= '0;
      r_ac <= '0;
      r_tr <= '0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_ri <= '0;
      r_rj <= '0;
      r_rk <= '0;
    end else begin
      r_ar <= w_ar_nxt;
      r_pc <= w_pc_nxt;
      r_dr <= w_dr_nxt;
      r_r  <= w_r_nxt;
      r_ac <= w_ac_nxt;
      r_tr <= w_tr_nxt;
      r_r1 <= w_r1_nxt;
      r_r2 <= w_r2_nxt;
      r_ri <= w_ri_nxt;
      r_rj <= w_rj_nxt;
      r_rk <= w_rk_nxt;
    end
  end

  assign ar = r_ar;
  assign pc = r_pc;
  assign dr = r_dr;
  assign r  = r_r;
  assign ac = r_ac;
  assign tr = r_tr;
  assign r1 = r_r1;
  assign r2 = r_r2;
  assign ri = r_ri;
  assign rj = r_rj;
  assign rk = r_rk;
  assign z  = (r_ac == '0);

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: array-based reference model indexed by destination code,
// randomized traffic plus directed reset, sweep, wrap, priority and hold cases.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] busin;
  logic [3:0]  write_en;
  logic [4:0]  inc_en;
  logic [3:0]  clr_en;
  logic [7:0]  ar, pc, dr, r, r1, r2, ri, rj, rk;
  logic [15:0] ac, tr;
  logic        z;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bank dut (
    .clk(clk), .rst_n(rst_n), .busin(busin), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en),
    .ar(ar), .pc(pc), .dr(dr), .r(r), .ac(ac), .tr(tr),
    .r1(r1), .r2(r2), .ri(ri), .rj(rj), .rk(rk), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT outputs viewed as an array indexed by destination code
  logic [15:0] d [1:11];
  assign d[1]  = {8'h00, ar};
  assign d[2]  = {8'h00, pc};
  assign d[3]  = {8'h00, dr};
  assign d[4]  = {8'h00, r};
  assign d[5]  = ac;
  assign d[6]  = tr;
  assign d[7]  = {8'h00, r1};
  assign d[8]  = {8'h00, r2};
  assign d[9]  = {8'h00, ri};
  assign d[10] = {8'h00, rj};
  assign d[11] = {8'h00, rk};

  string nm [1:11] = '{"ar", "pc", "dr", "r", "ac", "tr", "r1", "r2", "ri", "rj", "rk"};
  int inc_dst [5] = '{2, 9, 10, 11, 5};
  int clr_dst [4] = '{9, 10, 11, 5};

  // Reference model: one entry per destination code
  logic [15:0] m [1:11];

  function automatic logic [15:0] model_next(int c);
    logic [15:0] v;
    logic [15:0] mask;
    mask = (c == 5 || c == 6) ? 16'hFFFF : 16'h00FF;
    v = m[c];
    for (int b = 0; b < 5; b++)
      if (inc_en[b] && inc_dst[b] == c) v = (v + 16'd1) & mask;
    if (int'(write_en) == c) v = busin & mask;
    for (int b = 0; b < 4; b++)
      if (clr_en[b] && clr_dst[b] == c) v = 16'h0000;
    return v;
  endfunction

  initial for (int c = 1; c <= 11; c++) m[c] = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 1; c <= 11; c++) m[c] <= 16'h0000;
    end else begin
      for (int c = 1; c <= 11; c++) m[c] <= model_next(c);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    for (int c = 1; c <= 11; c++) chk(nm[c], d[c], m[c]);
    chk("z", {15'd0, z}, {15'd0, (m[5] == 16'h0000)});
  end

  task automatic idle();
    write_en = 4'd0;
    inc_en   = 5'd0;
    clr_en   = 4'd0;
  endtask

  // Drive one cycle of controls, then return #1 after the edge with controls idle
  task automatic apply(input logic [3:0] we, input logic [4:0] ie,
                       input logic [3:0] ce, input logic [15:0] b);
    write_en = we;
    inc_en   = ie;
    clr_en   = ce;
    busin    = b;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int c = 1; c <= 11; c++) chk({tag, "_", nm[c]}, d[c], 16'h0000);
    chk({tag, "_z"}, {15'd0, z}, 16'h0001);
  endtask

  initial begin
    rst_n = 1'b0;
    busin = 16'h0000;
    idle();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("por");

    // Load sweep
    for (int c = 1; c <= 11; c++) apply(4'(c), 5'd0, 4'd0, 16'hA55A);
    for (int c = 1; c <= 11; c++)
      chk({"sweep_", nm[c]}, d[c], (c == 5 || c == 6) ? 16'hA55A : 16'h005A);
    apply(4'd0, 5'd0, 4'd0, 16'h1111);
    for (int c = 12; c <= 15; c++) apply(4'(c), 5'd0, 4'd0, 16'h2222);
    chk("nocode_ac", ac, 16'hA55A);
    chk("nocode_ar", {8'h00, ar}, 16'h005A);

    // Wrap-around
    apply(4'd2, 5'd0, 4'd0, 16'h00FF);
    apply(4'd0, 5'b00001, 4'd0, 16'h0000);
    chk("wrap_pc", {8'h00, pc}, 16'h0000);
    apply(4'd5, 5'd0, 4'd0, 16'hFFFF);
    chk("pre_wrap_z", {15'd0, z}, 16'h0000);
    apply(4'd0, 5'b10000, 4'd0, 16'h0000);
    chk("wrap_ac", ac, 16'h0000);
    chk("wrap_z", {15'd0, z}, 16'h0001);
    apply(4'd9, 5'd0, 4'd0, 16'h12FF);
    apply(4'd0, 5'b00010, 4'd0, 16'h0000);
    chk("wrap_ri", {8'h00, ri}, 16'h0000);

    // Priority on one register
    apply(4'd11, 5'd0, 4'd0, 16'h0010);
    apply(4'd11, 5'b01000, 4'd0, 16'h0033);
    chk("prio_load_rk", {8'h00, rk}, 16'h0033);
    apply(4'd11, 5'd0, 4'd0, 16'h0010);
    apply(4'd11, 5'b01000, 4'b0100, 16'h0033);
    chk("prio_clr_rk", {8'h00, rk}, 16'h0000);
    apply(4'd2, 5'b00001, 4'd0, 16'h0077);
    chk("prio_load_pc", {8'h00, pc}, 16'h0077);

    // Concurrent independent ops
    apply(4'd9, 5'd0, 4'd0, 16'h0003);
    apply(4'd10, 5'd0, 4'd0, 16'h0007);
    apply(4'd5, 5'd0, 4'd0, 16'h0100);
    apply(4'd7, 5'b00110, 4'b1000, 16'h0042);
    chk("conc_r1", {8'h00, r1}, 16'h0042);
    chk("conc_ri", {8'h00, ri}, 16'h0004);
    chk("conc_rj", {8'h00, rj}, 16'h0008);
    chk("conc_ac", ac, 16'h0000);
    chk("conc_z", {15'd0, z}, 16'h0001);

    // Self-transfer hold
    apply(4'd5, 5'd0, 4'd0, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      apply(4'd5, 5'd0, 4'd0, ac);
      chk("hold_ac", ac, 16'h1234);
      chk("hold_z", {15'd0, z}, 16'h0000);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ce;
      for (int b = 0; b < 4; b++) ce[b] = ($urandom_range(0, 7) == 0);
      apply(4'($urandom_range(0, 15)), 5'($urandom), ce,
            ($urandom_range(0, 5) == 0) ? ac : 16'($urandom));
    end

    // Mid-cycle asynchronous reset with controls pending
    write_en = 4'd5;
    inc_en   = 5'b11111;
    clr_en   = 4'd0;
    busin    = 16'hBEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(posedge clk);
    #1;
    chk_all_zero("arst_hold");
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("post_rst");

    // More random traffic after reset
    for (int i = 0; i < 100; i++)
      apply(4'($urandom_range(0, 15)), 5'($urandom), 4'($urandom & 32'h5), 16'($urandom));

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
